// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: command opcodes, FSM states
// and the constants the core falls back to on reset.
package lfsr_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SEED = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // x^3 + x^2 + 1, maximal length (period 7) for a 3-bit register
    localparam logic [2:0] DEFAULT_TAPS = 3'b110;

    // Reset value is {zeros, 1}: nonzero, so the LFSR can never lock up
    localparam int RESET_SEED = 1;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register. Shifts left, feedback enters at bit 0.
// A load takes priority over a step in the same cycle.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;

    assign w_fb   = ^(r_state & TAPS);
    assign w_next = {r_state[WIDTH-2:0], w_fb};

    // State register: reset to the fixed seed, load wins over step
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            r_state <= WIDTH'(RESET_SEED);
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer around lfsr_core: SEED loads a nonzero state,
// RUN streams N states over a valid/ready port, abort cuts a RUN short.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_seed,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic             seed_err
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_done;
    logic             r_seed_err;

    logic             w_cmd_fire;
    logic             w_seed_cmd;
    logic             w_seed_zero;
    logic             w_load;
    logic             w_run_start;
    logic             w_hs;
    logic             w_final;
    logic [WIDTH-1:0] w_lfsr_state;

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_seed_cmd  = w_cmd_fire && (cmd_op == OP_SEED);
    assign w_seed_zero = (cmd_seed == '0);
    assign w_load      = w_seed_cmd && !w_seed_zero;
    // A zero-length RUN is accepted and dropped: no beats, no done
    assign w_run_start = w_cmd_fire && (cmd_op == OP_RUN) && (cmd_count != '0);
    assign w_hs        = out_valid && out_ready;
    assign w_final     = w_hs && (r_remaining == CNT_W'(1));

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .seed  (cmd_seed),
        .step  (w_hs),
        .state (w_lfsr_state)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the final handshake ends a RUN even if abort is also high
    always_comb begin
        // NOTE: default first so every path assigns w_next_state; otherwise
        // synthesis infers a latch to hold the value on unlisted paths.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_run_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_final || abort) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Beat counter: loaded on RUN start, decremented per handshake, cleared on abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
        end else if (w_run_start) begin
            r_remaining <= cmd_count;
        end else if ((r_state == ST_RUN) && abort && !w_final) begin
            r_remaining <= '0;
        end else if (w_hs) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // One-cycle completion pulse and sticky zero-seed flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_seed_cmd) begin
                r_seed_err <= w_seed_zero;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = w_lfsr_state;
    assign out_last  = out_valid && (r_remaining == CNT_W'(1));
    assign done      = r_done;
    assign seed_err  = r_seed_err;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: a cycle-level behavioural model checked
// every cycle, plus literal beat sequences for each scenario.
module tb_lfsr_seq_ctrl;

    localparam int         W     = 3;
    localparam int         C     = 8;
    localparam logic [W-1:0] TAPS = 3'b110;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_seed;
    logic [C-1:0] cmd_count;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         done;
    logic         busy;
    logic         seed_err;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_seq_ctrl #(.WIDTH(W), .TAPS(TAPS), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_seed  (cmd_seed),
        .cmd_count (cmd_count),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy),
        .seed_err  (seed_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec step function: feedback is the parity of tapped bits, shifted in at bit 0
    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (TAPS[i]) fb = fb ^ s[i];
        end
        return {s[W-2:0], fb};
    endfunction

    // Behavioural model: what the sequencer must present after each edge
    logic         m_active;
    logic [W-1:0] m_lfsr;
    int           m_rem;
    logic         m_done;
    logic         m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_lfsr   <= 3'b001;
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (cmd_valid && cmd_op == 2'b01) begin
                if (cmd_seed != 0) begin
                    m_lfsr <= cmd_seed;
                    m_err  <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
            end
            if (cmd_valid && cmd_op == 2'b10 && cmd_count != 0) begin
                m_active <= 1'b1;
                m_rem    <= int'(cmd_count);
            end
        end else begin
            m_done <= out_ready && (m_rem == 1);
            if (out_ready) begin
                m_lfsr <= model_step(m_lfsr);
                m_rem  <= m_rem - 1;
            end
            if ((out_ready && m_rem == 1) || abort) m_active <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            check("cmd_ready", cmd_ready, !m_active);
            check("out_valid", out_valid, m_active);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("seed_err", seed_err, m_err);
            if (m_active) begin
                check("out_data", out_data, m_lfsr);
                check("out_last", out_last, m_rem == 1);
            end else begin
                check("out_last_idle", out_last, 1'b0);
            end
        end
    end

    // Beat collector and done counter for the literal checks
    logic [W-1:0] beats[$];
    logic         lasts[$];
    int           done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
            end
            if (done) done_cnt++;
        end
    end

    logic [W-1:0] exp_q[$];
    int           beat_base;
    int           done_base;

    task automatic mark();
        beat_base = beats.size();
        done_base = done_cnt;
    endtask

    task automatic check_beats(input string name, input bit last_at_end, input int exp_done);
        int n;
        n = beats.size() - beat_base;
        check({name, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({name, "_data"}, beats[beat_base + i], exp_q[i]);
            check({name, "_last"}, lasts[beat_base + i], last_at_end && (i == exp_q.size() - 1));
        end
        check({name, "_done"}, done_cnt - done_base, exp_done);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] seed, input logic [C-1:0] cnt);
        int t;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_seed  = seed;
        cmd_count = cnt;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_seed_err", seed_err, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_out_data", out_data, 3'b001);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_seed  = '0;
        cmd_count = '0;
        abort     = 1'b0;
        out_ready = 1'b1;

        check("model_step_001", model_step(3'b001), 3'b010);
        check("model_step_100", model_step(3'b100), 3'b001);
        do_reset();

        // 1: full period from reset
        mark();
        send_cmd(2'b10, '0, 8'd7);
        wait_idle();
        exp_q = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
        check_beats("t1", 1'b1, 1);
        check("t1_busy", busy, 1'b0);

        // 2: seeded run, then a continuation run
        send_cmd(2'b01, 3'b101, '0);
        mark();
        send_cmd(2'b10, '0, 8'd3);
        wait_idle();
        exp_q = '{3'b101, 3'b011, 3'b111};
        check_beats("t2a", 1'b1, 1);
        mark();
        send_cmd(2'b10, '0, 8'd1);
        wait_idle();
        exp_q = '{3'b110};
        check_beats("t2b", 1'b1, 1);

        // 3: zero seed rejected, zero count ignored, good seed clears error
        do_reset();
        send_cmd(2'b01, 3'b000, '0);
        check("t3_seed_err_set", seed_err, 1'b1);
        mark();
        send_cmd(2'b10, '0, 8'd0);
        @(posedge clk); #1;
        check("t3_zero_count_busy", busy, 1'b0);
        exp_q = '{};
        check_beats("t3_zero", 1'b1, 0);
        mark();
        send_cmd(2'b10, '0, 8'd1);
        wait_idle();
        exp_q = '{3'b001};
        check_beats("t3_run", 1'b1, 1);
        send_cmd(2'b01, 3'b011, '0);
        check("t3_seed_err_clr", seed_err, 1'b0);

        // 4: backpressure on beat 2
        send_cmd(2'b01, 3'b001, '0);
        mark();
        send_cmd(2'b10, '0, 8'd4);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t4_hold_data", out_data, 3'b010);
            check("t4_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        wait_idle();
        exp_q = '{3'b001, 3'b010, 3'b101, 3'b011};
        check_beats("t4", 1'b1, 1);

        // 5: abort on the 2nd handshake
        send_cmd(2'b01, 3'b001, '0);
        mark();
        send_cmd(2'b10, '0, 8'd10);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        @(posedge clk); #1;
        exp_q = '{3'b001, 3'b010};
        check_beats("t5", 1'b0, 0);
        mark();
        send_cmd(2'b10, '0, 8'd1);
        wait_idle();
        exp_q = '{3'b101};
        check_beats("t5_next", 1'b1, 1);

        // 5b: abort on the final handshake still completes normally
        send_cmd(2'b01, 3'b001, '0);
        mark();
        send_cmd(2'b10, '0, 8'd2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5b_done_pulse", done, 1'b1);
        @(posedge clk); #1;
        exp_q = '{3'b001, 3'b010};
        check_beats("t5b", 1'b1, 1);

        // 6: reset mid-RUN
        send_cmd(2'b01, 3'b011, '0);
        send_cmd(2'b10, '0, 8'd5);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        mark();
        send_cmd(2'b10, '0, 8'd1);
        wait_idle();
        exp_q = '{3'b001};
        check_beats("t6", 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
